// File: rtl/jk_drv_pkg.sv
// rtl/jk_drv_pkg.sv - shared types and helpers for the JK bank driver
package jk_drv_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'b00,
      TOGGLE = 2'b01,
      CLEAR  = 2'b10,
      SET    = 2'b11
   } cmd_mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      WAIT  = 2'b10,
      CHECK = 2'b11
   } state_t;

   // Bits needed to count 0..max_retry; never narrower than one bit
   function automatic int retry_width(input int max_retry);
      return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
   endfunction

endpackage

// File: rtl/jk_excite.sv
// rtl/jk_excite.sv - minimal JK excitation toward a target value
module jk_excite
   import jk_drv_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] exp_val,
   input  logic [WIDTH-1:0] mask,
   input  logic             first,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k
);

   // A first-attempt toggle pulses J=K on the mask; everything else sets/clears only wrong bits
   always_comb begin
      j = '0;
      k = '0;
      if (first && (cmd_mode_t'(mode) == TOGGLE)) begin
         j = mask;
         k = mask;
      end else begin
         j = exp_val & ~q;
         k = ~exp_val & q;
      end
   end

endmodule

// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - drives a JK flip-flop bank to a requested value and confirms it
module jk_bank_driver
   import jk_drv_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SETTLE    = 1,
   parameter int MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   input  logic [WIDTH-1:0] q_fb,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int             RW          = retry_width(MAX_RETRY);
   localparam logic [RW-1:0]  RETRY_LIMIT = RW'(MAX_RETRY);
   localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] exp_r;
   logic [WIDTH-1:0] exp_next;
   logic [WIDTH-1:0] exp_new;
   logic [WIDTH-1:0] ex_exp;
   logic [WIDTH-1:0] ex_j;
   logic [WIDTH-1:0] ex_k;
   logic [WIDTH-1:0] j_next;
   logic [WIDTH-1:0] k_next;
   logic [3:0]       settle_cnt;
   logic [3:0]       settle_next;
   logic [RW-1:0]    retry_cnt;
   logic [RW-1:0]    retry_next;
   logic             accept;
   logic             match;
   logic             done_next;
   logic             err_next;

   assign accept = cmd_valid && cmd_ready && (state == IDLE);
   assign match  = (q_fb == exp_r);

   // Target value of the command being presented; q_fb here is the pre-command bank value
   always_comb begin
      case (cmd_mode_t'(cmd_mode))
         LOAD:    exp_new = cmd_data;
         TOGGLE:  exp_new = q_fb ^ cmd_data;
         CLEAR:   exp_new = '0;
         default: exp_new = '1;
      endcase
   end

   // The first drive is computed straight from q_fb at the accept edge, so q0 needs no register;
   // retries reuse the same excitation with first=0, which is always LOAD-style toward exp_r
   assign ex_exp = accept ? exp_new : exp_r;

   jk_excite #(
      .WIDTH (WIDTH)
   ) u_excite (
      .mode    (cmd_mode),
      .q       (q_fb),
      .exp_val (ex_exp),
      .mask    (cmd_data),
      .first   (accept),
      .j       (ex_j),
      .k       (ex_k)
   );

   // Next-state and next-output logic; J/K are nonzero only on edges that enter DRIVE
   always_comb begin
      state_next  = state;
      exp_next    = exp_r;
      settle_next = settle_cnt;
      retry_next  = retry_cnt;
      j_next      = '0;
      k_next      = '0;
      done_next   = 1'b0;
      err_next    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = DRIVE;
               exp_next   = exp_new;
               retry_next = '0;
               j_next     = ex_j;
               k_next     = ex_k;
            end
         end
         DRIVE: begin
            settle_next = 4'd0;
            if (SETTLE == 0) begin
               state_next = CHECK;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_next = CHECK;
            end else begin
               settle_next = settle_cnt + 4'd1;
            end
         end
         CHECK: begin
            if (match) begin
               done_next  = 1'b1;
               retry_next = '0;
               state_next = IDLE;
            end else if (retry_cnt < RETRY_LIMIT) begin
               retry_next = retry_cnt + 1'b1;
               state_next = DRIVE;
               j_next     = ex_j;
               k_next     = ex_k;
            end else begin
               err_next   = 1'b1;
               retry_next = '0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, capture registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         exp_r      <= '0;
         settle_cnt <= 4'd0;
         retry_cnt  <= '0;
         J          <= '0;
         K          <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
         cmd_ready  <= 1'b0;
      end else begin
         state      <= state_next;
         exp_r      <= exp_next;
         settle_cnt <= settle_next;
         retry_cnt  <= retry_next;
         J          <= j_next;
         K          <= k_next;
         done       <= done_next;
         err        <= err_next;
         busy       <= (state_next != IDLE);
         cmd_ready  <= (state_next == IDLE);
      end
   end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - self-checking bench for jk_bank_driver with a JK bank model
module tb_jk_bank_driver;
   import jk_drv_pkg::*;

   localparam int WIDTH     = 8;
   localparam int SETTLE    = 1;
   localparam int MAX_RETRY = 3;
   localparam int LAT_OK    = 2 + SETTLE;
   localparam int LAT_ERR   = (MAX_RETRY + 1) * (2 + SETTLE);

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_mode;
   logic [WIDTH-1:0] cmd_data;
   logic [WIDTH-1:0] J;
   logic [WIDTH-1:0] K;
   logic [WIDTH-1:0] q_fb;
   logic             busy;
   logic             done;
   logic             err;

   logic [WIDTH-1:0] bank_q;
   logic [WIDTH-1:0] stuck0;
   logic             preload_en;
   logic [WIDTH-1:0] preload_val;

   int checks;
   int errors;

   jk_bank_driver #(
      .WIDTH     (WIDTH),
      .SETTLE    (SETTLE),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_data  (cmd_data),
      .J         (J),
      .K         (K),
      .q_fb      (q_fb),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank of JK flip-flops; stuck0 bits read back as 0 whatever the flop holds
   always @(posedge clk) begin
      if (preload_en) bank_q <= preload_val;
      else            bank_q <= (J & ~bank_q) | (~K & bank_q);
   end
   assign q_fb = bank_q & ~stuck0;

   typedef struct {
      logic [7:0] pre;
      logic [7:0] stuck;
      logic [1:0] mode;
      logic [7:0] data;
      logic       ok;
      int         lat;
      logic [7:0] j;
      logic [7:0] k;
      logic [7:0] q;
      int         drives;
   } vec_t;

   vec_t tbl[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic preload(input logic [7:0] v, input logic [7:0] s);
      stuck0      = s;
      preload_en  = 1'b1;
      preload_val = v;
      step();
      preload_en  = 1'b0;
   endtask

   // Issue one command and follow it until done/err, checking the whole transaction
   task automatic run_cmd(input string tag, input logic [1:0] mode, input logic [7:0] data,
                          input logic ok, input int exp_lat, input logic [7:0] exp_j,
                          input logic [7:0] exp_k, input logic [7:0] exp_q, input int exp_drives);
      int lat;
      int drives;
      int waitc;
      bit got_done;
      bit got_err;
      bit jk_bad;
      bit overlap;
      waitc = 0;
      while (!cmd_ready && waitc < 20) begin
         step();
         waitc++;
      end
      chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_mode  = mode;
      cmd_data  = data;
      step();
      cmd_valid = 1'b0;
      chk({tag, " J"}, 32'(J), 32'(exp_j));
      chk({tag, " K"}, 32'(K), 32'(exp_k));
      lat = 0; drives = 0; got_done = 0; got_err = 0; jk_bad = 0; overlap = 0;
      while (lat < 40) begin
         if ((J | K) != 0) drives++;
         if ((J & K) != 0 && !(mode == TOGGLE && lat == 0)) jk_bad = 1;
         if (done && err) overlap = 1;
         if (done || err) begin
            got_done = done;
            got_err  = err;
            break;
         end
         step();
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " done"}, 32'(got_done), 32'(ok));
      chk({tag, " err"}, 32'(got_err), 32'(!ok));
      chk({tag, " q"}, 32'(q_fb), 32'(exp_q));
      chk({tag, " drives"}, 32'(drives), 32'(exp_drives));
      chk({tag, " jk_both"}, 32'(jk_bad), 32'd0);
      chk({tag, " done_err_overlap"}, 32'(overlap), 32'd0);
      step();
      chk({tag, " pulse_end"}, 32'(done | err), 32'd0);
      chk({tag, " ready_after"}, 32'(cmd_ready), 32'd1);
   endtask

   function automatic logic [7:0] model_exp(input logic [1:0] m, input logic [7:0] d,
                                            input logic [7:0] q0);
      case (m)
         2'b00:   return d;
         2'b01:   return q0 ^ d;
         2'b10:   return 8'h00;
         default: return 8'hFF;
      endcase
   endfunction

   initial begin
      int dcount;
      bit bad;
      logic [7:0] pre, stk, dat, q0, e, jj, kk;
      logic [1:0] md;
      logic fail;

      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_mode    = 2'b00;
      cmd_data    = 8'h00;
      stuck0      = 8'h00;
      preload_en  = 1'b1;
      preload_val = 8'h00;

      //           pre    stuck  mode   data   ok  lat      j      k      q      drives
      tbl[0] = '{8'h3C, 8'h00, 2'b00, 8'hA5, 1, LAT_OK,  8'h81, 8'h18, 8'hA5, 1};
      tbl[1] = '{8'hA5, 8'h00, 2'b01, 8'h0F, 1, LAT_OK,  8'h0F, 8'h0F, 8'hAA, 1};
      tbl[2] = '{8'h00, 8'h01, 2'b00, 8'h01, 0, LAT_ERR, 8'h01, 8'h00, 8'h00, 4};
      tbl[3] = '{8'hFF, 8'h00, 2'b11, 8'h5A, 1, LAT_OK,  8'h00, 8'h00, 8'hFF, 0};
      tbl[4] = '{8'h5A, 8'h00, 2'b10, 8'hFF, 1, LAT_OK,  8'h00, 8'h5A, 8'h00, 1};
      tbl[5] = '{8'h00, 8'h00, 2'b00, 8'h00, 1, LAT_OK,  8'h00, 8'h00, 8'h00, 0};
      tbl[6] = '{8'hF0, 8'h00, 2'b01, 8'hFF, 1, LAT_OK,  8'hFF, 8'hFF, 8'h0F, 1};

      // Reset state
      step(); step(); step();
      chk("rst J", 32'(J), 32'd0);
      chk("rst K", 32'(K), 32'd0);
      chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      rst        = 1'b0;
      preload_en = 1'b0;
      step();
      chk("post_rst cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst busy", 32'(busy), 32'd0);

      // Directed table
      for (int i = 0; i < 7; i++) begin
         preload(tbl[i].pre, tbl[i].stuck);
         run_cmd($sformatf("vec%0d", i), tbl[i].mode, tbl[i].data, tbl[i].ok, tbl[i].lat,
                 tbl[i].j, tbl[i].k, tbl[i].q, tbl[i].drives);
      end
      stuck0 = 8'h00;

      // Reset during WAIT aborts silently; a fresh CLEAR then completes
      preload(8'h00, 8'h00);
      cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_data = 8'hFF;
      step();
      cmd_valid = 1'b0;
      chk("abort drive J", 32'(J), 32'hFF);
      chk("abort drive busy", 32'(busy), 32'd1);
      step();
      chk("abort wait J", 32'(J), 32'd0);
      rst = 1'b1;
      step();
      chk("abort J", 32'(J), 32'd0);
      chk("abort K", 32'(K), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort cmd_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         if (done || err) bad = 1;
         step();
      end
      chk("abort no_pulse", 32'(bad), 32'd0);
      run_cmd("clear_after_abort", 2'b10, 8'h00, 1, LAT_OK, 8'h00, 8'hFF, 8'h00, 1);

      // cmd_valid held through a busy command with changing data
      preload(8'h00, 8'h00);
      cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_data = 8'h11;
      step();
      bad = 0;
      cmd_data = 8'h22;
      if (cmd_ready || done) bad = 1;
      step();
      cmd_data = 8'h33;
      if (cmd_ready || done) bad = 1;
      step();
      cmd_data = 8'h44;
      if (cmd_ready || done) bad = 1;
      step();
      chk("hold busy_not_ready", 32'(bad), 32'd0);
      chk("hold first_done", 32'(done), 32'd1);
      chk("hold first_q", 32'(q_fb), 32'h11);
      chk("hold ready_at_done", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      chk("hold second J", 32'(J), 32'h44);
      chk("hold second K", 32'(K), 32'h11);
      dcount = 0;
      while (!done && dcount < 20) begin
         step();
         dcount++;
      end
      chk("hold second latency", 32'(dcount), 32'(LAT_OK));
      chk("hold second q", 32'(q_fb), 32'h44);
      step();

      // Randomized commands against the reference model
      for (int n = 0; n < 40; n++) begin
         pre  = 8'($urandom);
         stk  = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         md   = 2'($urandom_range(0, 3));
         dat  = 8'($urandom);
         q0   = pre & ~stk;
         e    = model_exp(md, dat, q0);
         if (md == 2'b01) begin
            jj = dat;
            kk = dat;
         end else begin
            jj = e & ~q0;
            kk = ~e & q0;
         end
         fail = ((e & stk) != 0);
         preload(pre, stk);
         run_cmd($sformatf("rnd%0d", n), md, dat, !fail, fail ? LAT_ERR : LAT_OK, jj, kk,
                 e & ~stk, fail ? (MAX_RETRY + 1) : (((jj | kk) != 0) ? 1 : 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
